axo_mem_xbar_rr: RTL and testbench

Parametrised N-CPU by M-memory crossbar for the Axolotl memory bus, the successor of `axo_mem_xbar`. It sits between the CPU-side `axo_mem_bus` ports and the memory-side `axo_mem_bus` ports and decodes each request against per-memory address regions. Each memory port has a round-robin arbiter with a grant lock that holds while a memory stalls. Requests to unmapped addresses can optionally receive a registered decode-error response.

---
 rtl/axo_mem_xbar_rr.sv | 211 +++++++++++++++++++++
 tb/tb_axo_mem_xbar_rr.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axo_mem_xbar_rr.sv
// axo_mem_xbar_rr: N-CPU x M-memory crossbar for the Axolotl memory bus.
// Each request is decoded against per-memory address regions. Each memory
// port has a round-robin arbiter whose grant stays locked while that memory
// stalls.
// Optional feature: define AXO_XBAR_DECERR_EN to return a registered
// decode-error response (ready=1, error=1) to requests for unmapped addresses.
// Bus arrays are flattened: CPU/memory k occupies slice [k*W +: W].
// mem_abits holds one 32-bit integer per memory.
module axo_mem_xbar_rr #(
  parameter int dlen = 32,
  parameter int alen = 32,
  parameter int cpus = 2,
  parameter int mems = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU-facing side
  input  logic [cpus-1:0]      i_cpu_re,
  input  logic [cpus-1:0]      i_cpu_we,
  input  logic [2*cpus-1:0]    i_cpu_asize,
  input  logic [alen*cpus-1:0] i_cpu_addr,
  input  logic [dlen*cpus-1:0] i_cpu_wdata,
  output logic [cpus-1:0]      o_cpu_ready,
  output logic [cpus-1:0]      o_cpu_error,
  output logic [dlen*cpus-1:0] o_cpu_rdata,
  // memory-facing side
  output logic [mems-1:0]      o_mem_re,
  output logic [mems-1:0]      o_mem_we,
  output logic [2*mems-1:0]    o_mem_asize,
  output logic [alen*mems-1:0] o_mem_addr,
  output logic [dlen*mems-1:0] o_mem_wdata,
  input  logic [mems-1:0]      i_mem_ready,
  input  logic [mems-1:0]      i_mem_error,
  input  logic [dlen*mems-1:0] i_mem_rdata,
  // region map
  input  logic [alen*mems-1:0] mem_base,
  input  logic [32*mems-1:0]   mem_abits
);

  localparam int CW = (cpus > 1) ? $clog2(cpus) : 1;
  localparam int MW = (mems > 1) ? $clog2(mems) : 1;

  // per-memory arbitration state
  logic [mems-1:0] r_busy;
  logic [CW-1:0]   r_owner [mems];
  logic [CW-1:0]   r_ptr   [mems];

  // decode results
  logic [cpus-1:0] w_req;
  logic [cpus-1:0] w_req_arb;
  logic [cpus-1:0] w_hit;
  logic [MW-1:0]   w_tgt   [cpus];
  logic [cpus-1:0] w_want  [mems];

  // grant results
  logic [mems-1:0] w_gv;
  logic [CW-1:0]   w_gidx  [mems];
  logic [CW-1:0]   w_nxt   [mems];

`ifdef AXO_XBAR_DECERR_EN
  logic [cpus-1:0] r_decerr;

  // One-cycle decode-error pulse; a held unmapped request re-arms every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_decerr <= '0;
    end else begin
      r_decerr <= ~r_decerr & w_req & ~w_hit;
    end
  end

  // A CPU that is receiving its error response does not compete for memories.
  always_comb begin
    w_req_arb = w_req & ~r_decerr;
  end
`else
  // Without decode-error support every request competes for arbitration.
  always_comb begin
    w_req_arb = w_req;
  end
`endif

  // Address decode: the lowest-indexed matching region wins.
  always_comb begin
    for (int unsigned c = 0; c < cpus; c++) begin
      w_req[c] = i_cpu_re[c] | i_cpu_we[c];
      w_hit[c] = 1'b0;
      w_tgt[c] = '0;
      for (int unsigned i = 0; i < mems; i++) begin
        if (!w_hit[c] &&
            ((i_cpu_addr[c*alen +: alen] >> mem_abits[i*32 +: 32]) ==
             (mem_base[i*alen +: alen]   >> mem_abits[i*32 +: 32]))) begin
          w_hit[c] = 1'b1;
          w_tgt[c] = MW'(i);
        end
      end
    end
  end

  // Request matrix: which CPUs want each memory this cycle.
  always_comb begin
    for (int unsigned i = 0; i < mems; i++) begin
      w_want[i] = '0;
      for (int unsigned c = 0; c < cpus; c++) begin
        w_want[i][c] = w_req_arb[c] & w_hit[c] & (w_tgt[c] == MW'(i));
      end
    end
  end

  // Grant selection: locked owner while busy, otherwise round-robin from r_ptr.
  // The wrap-around search is done as two priority passes: first the requesters
  // at or above the pointer, then any requester from index 0.
  always_comb begin
    for (int unsigned i = 0; i < mems; i++) begin
      w_gv[i]   = 1'b0;
      w_gidx[i] = '0;
      if (!rst) begin
        if (r_busy[i]) begin
          if (w_want[i][r_owner[i]]) begin
            w_gv[i]   = 1'b1;
            w_gidx[i] = r_owner[i];
          end
        end else begin
          for (int unsigned c = 0; c < cpus; c++) begin
            if (!w_gv[i] && w_want[i][c] && (CW'(c) >= r_ptr[i])) begin
              w_gv[i]   = 1'b1;
              w_gidx[i] = CW'(c);
            end
          end
          for (int unsigned c = 0; c < cpus; c++) begin
            if (!w_gv[i] && w_want[i][c]) begin
              w_gv[i]   = 1'b1;
              w_gidx[i] = CW'(c);
            end
          end
        end
      end
      w_nxt[i] = (int'(w_gidx[i]) == cpus - 1) ? '0 : w_gidx[i] + 1'b1;
    end
  end

  // Lock on stall, advance the pointer past the grantee on completion,
  // and release a lock whose owner has withdrawn its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int unsigned i = 0; i < mems; i++) begin
        r_owner[i] <= '0;
        r_ptr[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < mems; i++) begin
        if (w_gv[i]) begin
          if (i_mem_ready[i]) begin
            r_busy[i] <= 1'b0;
            r_ptr[i]  <= w_nxt[i];
          end else begin
            r_busy[i]  <= 1'b1;
            r_owner[i] <= w_gidx[i];
          end
        end else if (r_busy[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Forward the grantee's request to each memory; idle ports are driven to zero.
  always_comb begin
    o_mem_re    = '0;
    o_mem_we    = '0;
    o_mem_asize = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    for (int unsigned i = 0; i < mems; i++) begin
      for (int unsigned c = 0; c < cpus; c++) begin
        if (w_gv[i] && (w_gidx[i] == CW'(c))) begin
          o_mem_re[i]                 = i_cpu_re[c];
          o_mem_we[i]                 = i_cpu_we[c];
          o_mem_asize[i*2 +: 2]       = i_cpu_asize[c*2 +: 2];
          o_mem_addr[i*alen +: alen]  = i_cpu_addr[c*alen +: alen];
          o_mem_wdata[i*dlen +: dlen] = i_cpu_wdata[c*dlen +: dlen];
        end
      end
    end
  end

  // Return each memory's response to its grantee; everyone else sees zeros.
  always_comb begin
    o_cpu_ready = '0;
    o_cpu_error = '0;
    o_cpu_rdata = '0;
    for (int unsigned c = 0; c < cpus; c++) begin
      for (int unsigned i = 0; i < mems; i++) begin
        if (w_gv[i] && (w_gidx[i] == CW'(c))) begin
          o_cpu_ready[c]              = i_mem_ready[i];
          o_cpu_error[c]              = i_mem_error[i];
          o_cpu_rdata[c*dlen +: dlen] = i_mem_rdata[i*dlen +: dlen];
        end
      end
`ifdef AXO_XBAR_DECERR_EN
      if (r_decerr[c]) begin
        o_cpu_ready[c]              = 1'b1;
        o_cpu_error[c]              = 1'b1;
        o_cpu_rdata[c*dlen +: dlen] = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axo_mem_xbar_rr.sv
// Testbench for axo_mem_xbar_rr (2 CPUs x 4 memories): directed scenarios
// with literal expectations, plus a transaction-level reference model that
// is compared on every falling clock edge.
module tb_axo_mem_xbar_rr;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    c_re, c_we;
  logic [3:0]    c_asize;
  logic [63:0]   c_addr, c_wdata;
  logic [1:0]    o_ready, o_error;
  logic [63:0]   o_rdata;
  logic [3:0]    m_re, m_we;
  logic [7:0]    m_asize;
  logic [127:0]  m_addr, m_wdata;
  logic [3:0]    m_ready;
  logic [3:0]    m_error;
  logic [127:0]  m_rdata;
  logic [127:0]  mem_base;
  logic [127:0]  mem_abits;

  int unsigned   base_a  [4] = '{0, 4, 16, 32};
  int unsigned   abits_a [4] = '{2, 2, 4, 2};
  logic [31:0]   rdata_a [4] = '{32'hdeadbeef, 32'h01234567, 32'hbaadf00d, 32'hcafef00d};

  int n_tests = 0;
  int n_fail  = 0;

  axo_mem_xbar_rr #(.dlen(32), .alen(32), .cpus(2), .mems(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cpu_re   (c_re),
    .i_cpu_we   (c_we),
    .i_cpu_asize(c_asize),
    .i_cpu_addr (c_addr),
    .i_cpu_wdata(c_wdata),
    .o_cpu_ready(o_ready),
    .o_cpu_error(o_error),
    .o_cpu_rdata(o_rdata),
    .o_mem_re   (m_re),
    .o_mem_we   (m_we),
    .o_mem_asize(m_asize),
    .o_mem_addr (m_addr),
    .o_mem_wdata(m_wdata),
    .i_mem_ready(m_ready),
    .i_mem_error(m_error),
    .i_mem_rdata(m_rdata),
    .mem_base   (mem_base),
    .mem_abits  (mem_abits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int c, input logic re, input logic we, input logic [31:0] a);
    c_re[c]            = re;
    c_we[c]            = we;
    c_addr[c*32 +: 32] = a;
    c_wdata[c*32 +: 32] = 32'h5000_0000 | a | (32'(c) << 8);
  endtask

  // ---------------- reference model ----------------
  // A memory is either free (remembering who it served last) or held by one CPU.
  bit m_busy  [4];
  int m_owner [4];
  int m_ptr   [4];
  bit m_derr  [2];

  always @(posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0; m_owner[i] = 0; m_ptr[i] = 0;
    end
    m_derr[0] = 0; m_derr[1] = 0;
  end

  always @(negedge clk) begin
    int          tgt [2];
    bit          req [2];
    bit          blk [2];
    int          g   [4];
    int          best;
    int          d;
    longint      a;
    logic [127:0] e;
    for (int c = 0; c < 2; c++) begin
      req[c] = c_re[c] | c_we[c];
      tgt[c] = -1;
      a = longint'(c_addr[c*32 +: 32]);
      for (int i = 3; i >= 0; i--)
        if (a >= longint'(base_a[i]) && a < longint'(base_a[i]) + (longint'(1) << abits_a[i]))
          tgt[c] = i;
`ifdef AXO_XBAR_DECERR_EN
      blk[c] = m_derr[c];
`else
      blk[c] = 0;
`endif
    end
    for (int i = 0; i < 4; i++) begin
      g[i] = -1;
      if (!rst) begin
        if (m_busy[i]) begin
          if (req[m_owner[i]] && tgt[m_owner[i]] == i && !blk[m_owner[i]]) g[i] = m_owner[i];
        end else begin
          best = 2;
          for (int c = 0; c < 2; c++) begin
            d = (c - m_ptr[i] + 2) % 2;
            if (req[c] && tgt[c] == i && !blk[c] && d < best) begin
              best = d; g[i] = c;
            end
          end
        end
      end
      e = '0;
      if (g[i] >= 0)
        e = {c_re[g[i]], c_we[g[i]], c_asize[g[i]*2 +: 2], c_addr[g[i]*32 +: 32], c_wdata[g[i]*32 +: 32]};
      chk($sformatf("model_mem%0d", i),
          {m_re[i], m_we[i], m_asize[i*2 +: 2], m_addr[i*32 +: 32], m_wdata[i*32 +: 32]}, e);
    end
    for (int c = 0; c < 2; c++) begin
      e = '0;
      for (int i = 0; i < 4; i++)
        if (g[i] == c) e = {m_ready[i], m_error[i], rdata_a[i]};
`ifdef AXO_XBAR_DECERR_EN
      if (m_derr[c] && !rst) e = {1'b1, 1'b1, 32'h0};
`endif
      chk($sformatf("model_cpu%0d", c), {o_ready[c], o_error[c], o_rdata[c*32 +: 32]}, e);
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 0; m_owner[i] = 0; m_ptr[i] = 0;
      end
      m_derr[0] = 0; m_derr[1] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (g[i] >= 0) begin
          if (m_ready[i]) begin m_busy[i] = 0; m_ptr[i] = (g[i] + 1) % 2; end
          else begin m_busy[i] = 1; m_owner[i] = g[i]; end
        end else begin
          m_busy[i] = 0;
        end
      end
`ifdef AXO_XBAR_DECERR_EN
      for (int c = 0; c < 2; c++) m_derr[c] = !m_derr[c] && req[c] && tgt[c] < 0;
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst     = 1'b1;
    c_re    = '0;
    c_we    = '0;
    c_asize = {2'd1, 2'd2};
    c_addr  = '0;
    c_wdata = '0;
    m_ready = 4'hf;
    m_error = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      m_rdata[i*32 +: 32]   = rdata_a[i];
      mem_base[i*32 +: 32]  = base_a[i];
      mem_abits[i*32 +: 32] = abits_a[i];
    end
    #2;
    chk("reset_cpu_ready", 128'(o_ready), 128'(2'b00));
    chk("reset_mem_re", 128'({m_re, m_we}), 128'(8'h00));
    step(); step();
    rst = 1'b0;

    // parallel access to two different memories
    step();
    drv(0, 1, 0, 32'h0);
    drv(1, 1, 0, 32'h10);
    #2;
    chk("par_ready", 128'(o_ready), 128'(2'b11));
    chk("par_rdata0", 128'(o_rdata[31:0]), 128'(32'hdeadbeef));
    chk("par_rdata1", 128'(o_rdata[63:32]), 128'(32'hbaadf00d));
    step();
    drv(0, 0, 0, 32'h0); drv(1, 0, 0, 32'h0);

    // contention on mem1: grants alternate starting with CPU0
    step();
    drv(0, 1, 0, 32'h4); drv(1, 1, 0, 32'h4);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("cont_ready_%0d", k), 128'(o_ready), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      chk($sformatf("cont_error_%0d", k), 128'(o_error), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      step();
    end
    drv(0, 0, 0, 32'h0); drv(1, 0, 0, 32'h0);

    // lock: CPU1 holds mem3 through a 3-cycle stall, CPU0 waits behind it
    step();
    m_ready = 4'b0111;
    drv(1, 1, 0, 32'h20);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("lock_addr_%0d", k), 128'(m_addr[127:96]), 128'(32'h20));
      chk($sformatf("lock_ready_%0d", k), 128'(o_ready), 128'(2'b00));
      step();
      drv(0, 1, 1, 32'h21);
    end
    m_ready = 4'hf;
    #2;
    chk("lock_done_ready", 128'(o_ready), 128'(2'b10));
    chk("lock_done_addr", 128'(m_addr[127:96]), 128'(32'h20));
    step();
    #2;
    chk("lock_next_ready", 128'(o_ready), 128'(2'b01));
    chk("lock_next_addr", 128'(m_addr[127:96]), 128'(32'h21));
    chk("lock_next_we", 128'(m_we), 128'(4'b1000));
    step();
    drv(0, 0, 0, 32'h0); drv(1, 0, 0, 32'h0);

    // unmapped address 0x8
    step();
    drv(0, 1, 0, 32'h8);
    for (int k = 0; k < 10; k++) begin
      #2;
`ifdef AXO_XBAR_DECERR_EN
      chk($sformatf("dec_ready_%0d", k), 128'(o_ready[0]), 128'(k % 2));
      chk($sformatf("dec_error_%0d", k), 128'(o_error[0]), 128'(k % 2));
`else
      chk($sformatf("dec_ready_%0d", k), 128'(o_ready[0]), 128'(0));
`endif
      chk($sformatf("dec_rdata_%0d", k), 128'(o_rdata[31:0]), 128'(0));
      chk($sformatf("dec_mem_re_%0d", k), 128'(m_re), 128'(0));
      step();
    end
    drv(0, 0, 0, 32'h0);
    step(); step();

    // asynchronous reset while CPU1 holds mem2
    m_ready = 4'b1011;
    drv(1, 1, 0, 32'h14);
    step();
    drv(0, 1, 0, 32'h10);
    #1;
    chk("stall_addr", 128'(m_addr[95:64]), 128'(32'h14));
    rst = 1'b1;
    #1;
    chk("rst_async_ready", 128'(o_ready), 128'(2'b00));
    chk("rst_async_mem_re", 128'(m_re), 128'(4'b0000));
    step();
    m_ready = 4'hf;
    rst = 1'b0;
    #2;
    chk("rst_restart_ready", 128'(o_ready), 128'(2'b01));
    chk("rst_restart_addr", 128'(m_addr[95:64]), 128'(32'h10));
    step();
    #2;
    chk("rst_second_ready", 128'(o_ready), 128'(2'b10));
    step();
    drv(0, 0, 0, 32'h0); drv(1, 0, 0, 32'h0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
